// File: rtl/branch_hazard_ctrl_pkg.sv
// Shared encodings, slot type and helpers for the ID-stage branch hazard controller.
package branch_hazard_ctrl_pkg;

  // Cycles until a source operand is consumed, counted from the D stage.
  localparam logic [1:0] TUSE_BR   = 2'd0;
  localparam logic [1:0] TUSE_E    = 2'd1;
  localparam logic [1:0] TUSE_M    = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // Cycles after E entry until a writer's result exists.
  localparam logic [1:0] TNEW_LINK = 2'd0;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;

  // Comparator operand sources.
  localparam logic [1:0] FWD_GRF = 2'd0;
  localparam logic [1:0] FWD_E   = 2'd1;
  localparam logic [1:0] FWD_M   = 2'd2;
  localparam logic [1:0] FWD_W   = 2'd3;

  // One in-flight register writer.
  typedef struct packed {
    logic [4:0] dst;
    logic [1:0] tnew;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '{dst: 5'd0, tnew: 2'd0};

  // Tnew counts down as the writer advances one stage, stopping at zero.
  function automatic logic [1:0] sat_dec(input logic [1:0] x);
    return (x == TNEW_LINK) ? TNEW_LINK : x - 2'd1;
  endfunction

endpackage

// File: rtl/branch_hazard_ctrl_src_check.sv
// Per-source hazard check: finds the youngest in-flight writer of one source
// register and decides whether D must stall and where the operand comes from.
module hazard_src_check
  import branch_hazard_ctrl_pkg::*;
(
  input  logic       valid,
  input  logic [4:0] src,
  input  logic [1:0] tuse,
  input  slot_t      e_slot,
  input  slot_t      m_slot,
  input  slot_t      w_slot,
  output logic       stall,
  output logic [1:0] sel
);

  logic active;
  logic e_hit;
  logic m_hit;
  logic w_hit;

  // $0, unused sources and bubbles never take part in hazard detection.
  assign active = valid && (src != 5'd0) && (tuse != TUSE_NONE);
  assign e_hit  = active && (e_slot.dst == src);
  assign m_hit  = active && (m_slot.dst == src);
  assign w_hit  = active && (w_slot.dst == src);

  // Youngest matching slot decides; older matches are shadowed.
  always_comb begin
    // NOTE: every output gets a default before the priority chain so no path leaves it unassigned (no latch).
    stall = 1'b0;
    sel   = FWD_GRF;
    if (e_hit) begin
      stall = (e_slot.tnew > tuse);
      if (e_slot.tnew == TNEW_LINK) sel = FWD_E;
    end else if (m_hit) begin
      stall = (m_slot.tnew > tuse);
      if (m_slot.tnew == TNEW_LINK) sel = FWD_M;
    end else if (w_hit) begin
      // A writer in W has always finished, so this never stalls in practice.
      stall = (w_slot.tnew > tuse);
      if (w_slot.tnew == TNEW_LINK) sel = FWD_W;
    end
  end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// Hazard controller for the ID-stage branch comparator: shadow pipeline of
// in-flight writers (E, M, W), stall/forward decision and stall-cycle counter.
module branch_hazard_ctrl
  import branch_hazard_ctrl_pkg::*;
#(
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   d_valid,
  input  logic [4:0]             d_rs,
  input  logic [4:0]             d_rt,
  input  logic [1:0]             d_rs_tuse,
  input  logic [1:0]             d_rt_tuse,
  input  logic [4:0]             d_dst,
  input  logic [1:0]             d_tnew,
  output logic                   stall,
  output logic [1:0]             fwd_rs_sel,
  output logic [1:0]             fwd_rt_sel,
  output logic [STALL_CNT_W-1:0] br_stall_cnt
);

  localparam logic [STALL_CNT_W-1:0] CNT_ONE = STALL_CNT_W'(1);

  slot_t e_q;
  slot_t m_q;
  slot_t w_q;
  logic  rs_stall;
  logic  rt_stall;

  hazard_src_check u_rs_check (
    .valid  (d_valid),
    .src    (d_rs),
    .tuse   (d_rs_tuse),
    .e_slot (e_q),
    .m_slot (m_q),
    .w_slot (w_q),
    .stall  (rs_stall),
    .sel    (fwd_rs_sel)
  );

  hazard_src_check u_rt_check (
    .valid  (d_valid),
    .src    (d_rt),
    .tuse   (d_rt_tuse),
    .e_slot (e_q),
    .m_slot (m_q),
    .w_slot (w_q),
    .stall  (rt_stall),
    .sel    (fwd_rt_sel)
  );

  assign stall = rs_stall | rt_stall;

  // Advance the shadow pipeline; a stalled or empty D stage sends a bubble into E.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every slot samples the pre-edge value of the one before it.
    if (reset) begin
      e_q <= SLOT_EMPTY;
      m_q <= SLOT_EMPTY;
      w_q <= SLOT_EMPTY;
    end else begin
      e_q <= (d_valid && !stall) ? '{dst: d_dst, tnew: d_tnew} : SLOT_EMPTY;
      m_q <= '{dst: e_q.dst, tnew: sat_dec(e_q.tnew)};
      w_q <= '{dst: m_q.dst, tnew: sat_dec(m_q.tnew)};
    end
  end

  // Count stalled cycles, holding at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      br_stall_cnt <= '0;
    end else if (stall && (br_stall_cnt != '1)) begin
      br_stall_cnt <= br_stall_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Self-checking bench for branch_hazard_ctrl: directed scenarios plus a
// randomized run against an age-based model of in-flight writers.
module tb_branch_hazard_ctrl;
  import branch_hazard_ctrl_pkg::*;

  localparam int CW      = 3;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk;
  logic          reset;
  logic          d_valid;
  logic [4:0]    d_rs;
  logic [4:0]    d_rt;
  logic [1:0]    d_rs_tuse;
  logic [1:0]    d_rt_tuse;
  logic [4:0]    d_dst;
  logic [1:0]    d_tnew;
  logic          stall;
  logic [1:0]    fwd_rs_sel;
  logic [1:0]    fwd_rt_sel;
  logic [CW-1:0] br_stall_cnt;

  int checks = 0;
  int errors = 0;

  // Model: writer that entered E k cycles ago sits at index k (0=E,1=M,2=W)
  // with its original Tnew; its remaining latency is Tnew minus its age.
  logic [4:0] h_dst[3];
  logic [1:0] h_tnew[3];
  int         cnt_m;

  branch_hazard_ctrl #(.STALL_CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .d_valid      (d_valid),
    .d_rs         (d_rs),
    .d_rt         (d_rt),
    .d_rs_tuse    (d_rs_tuse),
    .d_rt_tuse    (d_rt_tuse),
    .d_dst        (d_dst),
    .d_tnew       (d_tnew),
    .stall        (stall),
    .fwd_rs_sel   (fwd_rs_sel),
    .fwd_rt_sel   (fwd_rt_sel),
    .br_stall_cnt (br_stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic void ref_src(input logic v, input logic [4:0] src, input logic [1:0] tuse,
                                  output logic st, output logic [1:0] sel);
    bit found;
    int rem;
    found = 1'b0;
    st    = 1'b0;
    sel   = 2'd0;
    if (v && src != 5'd0 && tuse != 2'd3) begin
      for (int k = 0; k < 3; k++) begin
        if (!found && h_dst[k] == src) begin
          found = 1'b1;
          rem   = int'(h_tnew[k]) - k;
          if (rem < 0) rem = 0;
          st  = (rem > int'(tuse));
          sel = (rem == 0) ? 2'(k + 1) : 2'd0;
        end
      end
    end
  endfunction

  task automatic set_d(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [1:0] rs_tu, input logic [1:0] rt_tu,
                       input logic [4:0] dst, input logic [1:0] tnew);
    d_valid   = v;
    d_rs      = rs;
    d_rt      = rt;
    d_rs_tuse = rs_tu;
    d_rt_tuse = rt_tu;
    d_dst     = dst;
    d_tnew    = tnew;
  endtask

  // Advance one clock and keep the model in step; returns at posedge+1.
  task automatic tick();
    logic s1, s2;
    logic [1:0] x1, x2;
    ref_src(d_valid, d_rs, d_rs_tuse, s1, x1);
    ref_src(d_valid, d_rt, d_rt_tuse, s2, x2);
    @(posedge clk);
    if (reset) begin
      for (int k = 0; k < 3; k++) begin
        h_dst[k]  = 5'd0;
        h_tnew[k] = 2'd0;
      end
      cnt_m = 0;
    end else begin
      if ((s1 || s2) && cnt_m < CNT_MAX) cnt_m++;
      h_dst[2]  = h_dst[1];
      h_tnew[2] = h_tnew[1];
      h_dst[1]  = h_dst[0];
      h_tnew[1] = h_tnew[0];
      h_dst[0]  = (d_valid && !(s1 || s2)) ? d_dst : 5'd0;
      h_tnew[0] = (d_valid && !(s1 || s2)) ? d_tnew : 2'd0;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_d(1'b0, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd0, TNEW_LINK);
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    set_d(1'b1, 5'd7, 5'd9, TUSE_BR, TUSE_BR, 5'd0, TNEW_LINK);
    #2;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0b exp=0", stall); end
    checks++; if (fwd_rs_sel !== FWD_GRF) begin errors++; $display("FAIL reset_rs_sel got=%0d exp=0", fwd_rs_sel); end
    checks++; if (fwd_rt_sel !== FWD_GRF) begin errors++; $display("FAIL reset_rt_sel got=%0d exp=0", fwd_rt_sel); end
    checks++; if (br_stall_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", br_stall_cnt); end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    set_d(1'b1, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd1, TNEW_LOAD);
    tick();
    set_d(1'b1, 5'd1, 5'd0, TUSE_BR, TUSE_NONE, 5'd0, TNEW_LINK);
    for (int c = 1; c <= 2; c++) begin
      #2;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL load_use_c%0d_stall got=%0b exp=1", c, stall); end
      tick();
    end
    #2;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL load_use_c3_stall got=%0b exp=0", stall); end
    checks++; if (fwd_rs_sel !== FWD_W) begin errors++; $display("FAIL load_use_c3_rs_sel got=%0d exp=3", fwd_rs_sel); end
    checks++; if (br_stall_cnt !== 3'd2) begin errors++; $display("FAIL load_use_cnt got=%0d exp=2", br_stall_cnt); end
    tick();
  endtask

  task automatic test_alu_branch();
    do_reset();
    set_d(1'b1, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd3, TNEW_ALU);
    tick();
    set_d(1'b1, 5'd0, 5'd3, TUSE_NONE, TUSE_BR, 5'd0, TNEW_LINK);
    #2;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL alu_br_c1_stall got=%0b exp=1", stall); end
    tick();
    #2;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_br_c2_stall got=%0b exp=0", stall); end
    checks++; if (fwd_rt_sel !== FWD_M) begin errors++; $display("FAIL alu_br_c2_rt_sel got=%0d exp=2", fwd_rt_sel); end
    tick();
    // Load feeding an ALU consumer costs a single cycle.
    set_d(1'b1, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd4, TNEW_LOAD);
    tick();
    set_d(1'b1, 5'd4, 5'd0, TUSE_E, TUSE_NONE, 5'd6, TNEW_ALU);
    #2;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL load_alu_c1_stall got=%0b exp=1", stall); end
    tick();
    #2;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL load_alu_c2_stall got=%0b exp=0", stall); end
    tick();
  endtask

  task automatic test_link_zero();
    do_reset();
    set_d(1'b1, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd31, TNEW_LINK);
    tick();
    set_d(1'b1, 5'd31, 5'd0, TUSE_BR, TUSE_NONE, 5'd0, TNEW_LINK);
    #2;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL link_stall got=%0b exp=0", stall); end
    checks++; if (fwd_rs_sel !== FWD_E) begin errors++; $display("FAIL link_rs_sel got=%0d exp=1", fwd_rs_sel); end
    tick();
    set_d(1'b1, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd0, TNEW_LOAD);
    tick();
    set_d(1'b1, 5'd0, 5'd0, TUSE_BR, TUSE_BR, 5'd0, TNEW_LINK);
    #2;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL zero_stall got=%0b exp=0", stall); end
    checks++; if (fwd_rs_sel !== FWD_GRF) begin errors++; $display("FAIL zero_rs_sel got=%0d exp=0", fwd_rs_sel); end
    tick();
  endtask

  task automatic test_shadowing();
    do_reset();
    set_d(1'b1, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd5, TNEW_LINK);
    tick();
    set_d(1'b1, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd5, TNEW_ALU);
    tick();
    set_d(1'b1, 5'd5, 5'd0, TUSE_BR, TUSE_NONE, 5'd0, TNEW_LINK);
    #2;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL shadow_c1_stall got=%0b exp=1", stall); end
    checks++; if (fwd_rs_sel !== FWD_GRF) begin errors++; $display("FAIL shadow_c1_rs_sel got=%0d exp=0", fwd_rs_sel); end
    tick();
    #2;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL shadow_c2_stall got=%0b exp=0", stall); end
    checks++; if (fwd_rs_sel !== FWD_M) begin errors++; $display("FAIL shadow_c2_rs_sel got=%0d exp=2", fwd_rs_sel); end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_d(1'b1, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd1, TNEW_LOAD);
    tick();
    set_d(1'b1, 5'd1, 5'd1, TUSE_BR, TUSE_BR, 5'd0, TNEW_LINK);
    #2;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL midrst_pre_stall got=%0b exp=1", stall); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #2;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL midrst_stall got=%0b exp=0", stall); end
    checks++; if (fwd_rs_sel !== FWD_GRF || fwd_rt_sel !== FWD_GRF) begin
      errors++; $display("FAIL midrst_sel got=%0d/%0d exp=0/0", fwd_rs_sel, fwd_rt_sel);
    end
    checks++; if (br_stall_cnt !== 3'd0) begin errors++; $display("FAIL midrst_cnt got=%0d exp=0", br_stall_cnt); end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int r = 1; r <= 5; r++) begin
      set_d(1'b1, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd2, TNEW_LOAD);
      tick();
      set_d(1'b1, 5'd2, 5'd0, TUSE_BR, TUSE_NONE, 5'd0, TNEW_LINK);
      tick();
      tick();
      tick();
      if (r >= 3) begin
        checks++;
        if (br_stall_cnt !== CW'((2 * r > CNT_MAX) ? CNT_MAX : 2 * r)) begin
          errors++; $display("FAIL sat_round%0d_cnt got=%0d exp=%0d", r, br_stall_cnt, (2 * r > CNT_MAX) ? CNT_MAX : 2 * r);
        end
      end
    end
  endtask

  task automatic test_random();
    logic s1, s2;
    logic [1:0] x1, x2;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      set_d($urandom_range(0, 4) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 2'($urandom_range(0, 2)));
      ref_src(d_valid, d_rs, d_rs_tuse, s1, x1);
      ref_src(d_valid, d_rt, d_rt_tuse, s2, x2);
      #2;
      checks++;
      if (stall !== (s1 | s2) || fwd_rs_sel !== x1 || fwd_rt_sel !== x2 || br_stall_cnt !== CW'(cnt_m)) begin
        errors++;
        $display("FAIL rand_%0d got stall=%0b rs=%0d rt=%0d cnt=%0d exp stall=%0b rs=%0d rt=%0d cnt=%0d",
                 i, stall, fwd_rs_sel, fwd_rt_sel, br_stall_cnt, s1 | s2, x1, x2, cnt_m);
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    cnt_m = 0;
    for (int k = 0; k < 3; k++) begin
      h_dst[k]  = 5'd0;
      h_tnew[k] = 2'd0;
    end
    set_d(1'b0, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd0, TNEW_LINK);
    @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_alu_branch();
    test_link_zero();
    test_shadowing();
    test_reset_mid_stall();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
